// File: rtl/obstacle_pkg.sv
// Shared constants for the obstacle block and the pipe-position store.
// No logic, so no latency or backpressure.
package obstacle_pkg;

    localparam int COORD_W  = 10;
    localparam int PIDX_W   = 2;

    localparam int SCREEN_H = 480;
    localparam int PIPE_W   = 80;
    localparam int BIRD_X   = 240;
    localparam int BIRD_W   = 20;
    localparam int BIRD_H   = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_e;

endpackage

// File: rtl/obstacle_hit_detect.sv
// Gap lookup plus bird/pipe overlap test; hit is 2 cycles after the inputs.
// No backpressure: one new sample per cycle; floor hit under OBSTACLE_GROUND_COLLIDE_EN.
module obstacle_hit_detect
    import obstacle_pkg::COORD_W;
    import obstacle_pkg::PIDX_W;
#(
    parameter int BIRD_X   = obstacle_pkg::BIRD_X,
    parameter int BIRD_W   = obstacle_pkg::BIRD_W,
    parameter int BIRD_H   = obstacle_pkg::BIRD_H,
    parameter int PIPE_W   = obstacle_pkg::PIPE_W,
    parameter int GAP_H    = 120,
    parameter int SCREEN_H = obstacle_pkg::SCREEN_H,
    parameter int GAP_TOP0 = 100,
    parameter int GAP_TOP1 = 220,
    parameter int GAP_TOP2 = 60,
    parameter int GAP_TOP3 = 300
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               eval_en,
    input  logic [COORD_W-1:0] pipe_x,
    input  logic [PIDX_W-1:0]  pipe_idx,
    input  logic [COORD_W-1:0] bird_y,
    output logic [COORD_W-1:0] gap_top,
    output logic               hit
);

    localparam logic [COORD_W:0] X_LO = (COORD_W+1)'(BIRD_X);
    localparam logic [COORD_W:0] X_HI = (COORD_W+1)'(BIRD_X + BIRD_W);

    logic [COORD_W-1:0] gap_top_d, gap_top_q;
    logic [COORD_W-1:0] px_q, by_q;
    logic               hit_d, hit_q;
    logic [COORD_W:0]   px_w, by_w, gt_w;
    logic               x_ovl, y_bad, gnd;

    always_comb begin
        gap_top_d = COORD_W'(GAP_TOP0);
        case (pipe_idx)
            2'd1:    gap_top_d = COORD_W'(GAP_TOP1);
            2'd2:    gap_top_d = COORD_W'(GAP_TOP2);
            2'd3:    gap_top_d = COORD_W'(GAP_TOP3);
            default: gap_top_d = COORD_W'(GAP_TOP0);
        endcase
    end

    // Compares run one bit wider so the off-screen value 640 cannot wrap into range.
    always_comb begin
        px_w  = {1'b0, px_q};
        by_w  = {1'b0, by_q};
        gt_w  = {1'b0, gap_top_q};
        x_ovl = (px_w < X_HI) && ((px_w + (COORD_W+1)'(PIPE_W)) > X_LO);
        y_bad = (by_w < gt_w) ||
                ((by_w + (COORD_W+1)'(BIRD_H)) > (gt_w + (COORD_W+1)'(GAP_H)));
`ifdef OBSTACLE_GROUND_COLLIDE_EN
        gnd   = (by_w == '0) ||
                ((by_w + (COORD_W+1)'(BIRD_H)) >= (COORD_W+1)'(SCREEN_H));
`else
        gnd   = 1'b0;
`endif
        hit_d = eval_en && ((x_ovl && y_bad) || gnd);
    end

`ifndef OBSTACLE_GROUND_COLLIDE_EN
    logic unused_floor;
    assign unused_floor = (SCREEN_H > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_top_q <= '0;
            px_q      <= '0;
            by_q      <= '0;
            hit_q     <= 1'b0;
        end else begin
            gap_top_q <= gap_top_d;
            px_q      <= pipe_x;
            by_q      <= bird_y;
            hit_q     <= hit_d;
        end
    end

    assign gap_top = gap_top_q;
    assign hit     = hit_q;

endmodule

// File: rtl/obstacle_logic.sv
// Game FSM over the hit pipeline; collision to lose=1 is 3 cycles.
// No backpressure; OBSTACLE_GROUND_COLLIDE_EN adds floor/ceiling hits.
module obstacle_logic
    import obstacle_pkg::COORD_W;
    import obstacle_pkg::PIDX_W;
    import obstacle_pkg::state_e;
    import obstacle_pkg::ST_IDLE;
    import obstacle_pkg::ST_PLAY;
    import obstacle_pkg::ST_HIT;
    import obstacle_pkg::ST_OVER;
#(
    parameter int BIRD_X       = obstacle_pkg::BIRD_X,
    parameter int BIRD_W       = obstacle_pkg::BIRD_W,
    parameter int BIRD_H       = obstacle_pkg::BIRD_H,
    parameter int PIPE_W       = obstacle_pkg::PIPE_W,
    parameter int GAP_H        = 120,
    parameter int SCREEN_H     = obstacle_pkg::SCREEN_H,
    parameter int DEATH_FRAMES = 30,
    parameter int GAP_TOP0     = 100,
    parameter int GAP_TOP1     = 220,
    parameter int GAP_TOP2     = 60,
    parameter int GAP_TOP3     = 300
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [COORD_W-1:0] pipe_x,
    input  logic [PIDX_W-1:0]  pipe_idx,
    input  logic [COORD_W-1:0] bird_y,
    output logic               count_en,
    output logic               game_rst,
    output logic               lose,
    output logic [COORD_W-1:0] gap_top,
    output logic [1:0]         state
);

    localparam int CNT_W = (DEATH_FRAMES > 2) ? $clog2(DEATH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEATH_FRAMES - 1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             lose_d, lose_q;
    logic             hit_q;
    logic             rst_req;

    obstacle_hit_detect #(
        .BIRD_X   (BIRD_X),
        .BIRD_W   (BIRD_W),
        .BIRD_H   (BIRD_H),
        .PIPE_W   (PIPE_W),
        .GAP_H    (GAP_H),
        .SCREEN_H (SCREEN_H),
        .GAP_TOP0 (GAP_TOP0),
        .GAP_TOP1 (GAP_TOP1),
        .GAP_TOP2 (GAP_TOP2),
        .GAP_TOP3 (GAP_TOP3)
    ) u_hit (
        .clk      (clk),
        .reset    (reset),
        .eval_en  (state_q == ST_PLAY),
        .pipe_x   (pipe_x),
        .pipe_idx (pipe_idx),
        .bird_y   (bird_y),
        .gap_top  (gap_top),
        .hit      (hit_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_req = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_PLAY;
                    rst_req = 1'b1;
                end
            end
            ST_PLAY: begin
                if (hit_q) begin
                    state_d = ST_HIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (cnt_q == '0) state_d = ST_OVER;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        lose_d = (state_d == ST_HIT) || (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lose_q  <= lose_d;
        end
    end

    // The restart pulse is suppressed while reset holds the FSM in IDLE.
    assign game_rst = rst_req && !reset;
    assign count_en = (state_q == ST_PLAY) && frame_tick;
    assign lose     = lose_q;
    assign state    = state_q;

endmodule

// File: tb/tb_obstacle_logic.sv
// Self-checking bench for obstacle_logic: directed scenarios plus randomized play
// checked against a frame-level reference model; honours OBSTACLE_GROUND_COLLIDE_EN.
module tb_obstacle_logic;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start;
    logic [9:0] pipe_x, bird_y;
    logic [1:0] pipe_idx;
    logic       count_en, game_rst, lose;
    logic [9:0] gap_top;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;
    int gaps [4] = '{100, 220, 60, 300};

    obstacle_logic dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .pipe_x     (pipe_x),
        .pipe_idx   (pipe_idx),
        .bird_y     (bird_y),
        .count_en   (count_en),
        .game_rst   (game_rst),
        .lose       (lose),
        .gap_top    (gap_top),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Geometry straight from the game rules: rectangles overlap strictly.
    function automatic bit model_hit(int px, int idx, int by);
        int  gt;
        bit  xo, yb, g;
        gt = gaps[idx];
        xo = (px < 240 + 20) && (px + 80 > 240);
        yb = (by < gt) || (by + 20 > gt + 120);
        g  = 1'b0;
`ifdef OBSTACLE_GROUND_COLLIDE_EN
        g  = (by == 0) || (by + 20 >= 480);
`endif
        return (xo && yb) || g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_safe();
        pipe_x = 10'd640; bird_y = 10'd200; pipe_idx = 2'd0;
        frame_tick = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        set_safe();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic go_play();
        start = 1'b1;
        #1;
        n_vec++; if (game_rst !== 1'b1) begin n_err++; $display("FAIL go_play game_rst: got %0b want 1", game_rst); end
        step();
        start = 1'b0;
        #1;
        n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL go_play state: got %0d want 1", state); end
        n_vec++; if (game_rst !== 1'b0) begin n_err++; $display("FAIL go_play game_rst_drop: got %0b want 0", game_rst); end
        step(); step();
    endtask

    task automatic test_reset();
        set_safe();
        reset = 1'b1; start = 1'b1; frame_tick = 1'b1;
        step();
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset state: got %0d want 0", state); end
        n_vec++; if (lose !== 1'b0) begin n_err++; $display("FAIL reset lose: got %0b want 0", lose); end
        n_vec++; if (gap_top !== 10'd0) begin n_err++; $display("FAIL reset gap_top: got %0d want 0", gap_top); end
        n_vec++; if (game_rst !== 1'b0) begin n_err++; $display("FAIL reset game_rst: got %0b want 0", game_rst); end
        reset = 1'b0; start = 1'b0;
        #1;
        n_vec++; if (count_en !== 1'b0) begin n_err++; $display("FAIL idle count_en: got %0b want 0", count_en); end
        frame_tick = 1'b0;
        step();
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL idle hold state: got %0d want 0", state); end
    endtask

    task automatic test_start();
        do_reset();
        go_play();
        for (int i = 0; i < 6; i++) begin
            frame_tick = 1'($urandom_range(0, 1));
            #1;
            n_vec++; if (count_en !== frame_tick) begin n_err++; $display("FAIL start count_en: got %0b want %0b", count_en, frame_tick); end
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic test_collide();
        do_reset();
        go_play();
        pipe_idx = 2'd1; pipe_x = 10'd200; bird_y = 10'd150;
        step();
        n_vec++; if (gap_top !== 10'd220) begin n_err++; $display("FAIL collide gap_top: got %0d want 220", gap_top); end
        n_vec++; if (lose !== 1'b0) begin n_err++; $display("FAIL collide lose_c1: got %0b want 0", lose); end
        step();
        n_vec++; if (lose !== 1'b0 || state !== 2'd1) begin n_err++; $display("FAIL collide c2: got lose=%0b state=%0d want 0/1", lose, state); end
        step();
        n_vec++; if (lose !== 1'b1) begin n_err++; $display("FAIL collide lose_c3: got %0b want 1", lose); end
        n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL collide state_c3: got %0d want 2", state); end
        frame_tick = 1'b1;
        #1;
        n_vec++; if (count_en !== 1'b0) begin n_err++; $display("FAIL collide count_en: got %0b want 0", count_en); end
        frame_tick = 1'b0;
    endtask

    // Continues from HIT entered by test_collide with a freshly loaded counter.
    task automatic test_hit_timer();
        for (int k = 1; k <= 30; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                start = 1'($urandom_range(0, 1));
                step();
                start = 1'b0;
                n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL timer idle k=%0d: got %0d want 2", k, state); end
            end
            frame_tick = 1'b1; start = 1'($urandom_range(0, 1));
            step();
            frame_tick = 1'b0; start = 1'b0;
            n_vec++; if (state !== ((k == 30) ? 2'd3 : 2'd2)) begin n_err++; $display("FAIL timer tick=%0d: got %0d want %0d", k, state, (k == 30) ? 3 : 2); end
        end
        n_vec++; if (lose !== 1'b1) begin n_err++; $display("FAIL over lose: got %0b want 1", lose); end
        set_safe();
        step(); step(); step();
        n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL over hold: got %0d want 3", state); end
        go_play();
        n_vec++; if (lose !== 1'b0) begin n_err++; $display("FAIL replay lose: got %0b want 0", lose); end
    endtask

    task automatic test_edges();
        int tp [7][3] = '{'{1, 200, 250}, '{1, 160, 150}, '{1, 200, 320}, '{1, 640, 150},
                          '{1, 260, 150}, '{1, 259, 150}, '{1, 200, 321}};
        bit exp;
        do_reset();
        go_play();
        for (int i = 0; i < 7; i++) begin
            pipe_idx = 2'(tp[i][0]); pipe_x = 10'(tp[i][1]); bird_y = 10'(tp[i][2]);
            exp = model_hit(tp[i][1], tp[i][0], tp[i][2]);
            step(); step(); step();
            n_vec++; if (state !== (exp ? 2'd2 : 2'd1) || lose !== exp) begin
                n_err++; $display("FAIL edge x=%0d y=%0d: got state=%0d lose=%0b want %0d/%0b",
                                  tp[i][1], tp[i][2], state, lose, exp ? 2 : 1, exp);
            end
            if (exp) begin do_reset(); go_play(); end
        end
    endtask

    task automatic test_tick_and_hit();
        do_reset();
        go_play();
        pipe_idx = 2'd1; pipe_x = 10'd200; bird_y = 10'd150;
        step();
        set_safe();
        step();
        frame_tick = 1'b1;
        #1;
        n_vec++; if (count_en !== 1'b1 || state !== 2'd1) begin n_err++; $display("FAIL tick_hit same: got count_en=%0b state=%0d want 1/1", count_en, state); end
        step();
        frame_tick = 1'b0;
        n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL tick_hit next: got %0d want 2", state); end
    endtask

    task automatic test_reset_mid_hit();
        for (int k = 0; k < 10; k++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end
        n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL midhit state: got %0d want 2", state); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++; if (state !== 2'd0 || lose !== 1'b0) begin n_err++; $display("FAIL midhit reset: got state=%0d lose=%0b want 0/0", state, lose); end
        n_vec++; if (gap_top !== 10'd0) begin n_err++; $display("FAIL midhit gap_top: got %0d want 0", gap_top); end
    endtask

    task automatic test_ground();
        bit exp;
        do_reset();
        go_play();
        pipe_idx = 2'd1; pipe_x = 10'd500; bird_y = 10'd470;
        exp = model_hit(500, 1, 470);
        step(); step(); step();
        n_vec++; if (state !== (exp ? 2'd2 : 2'd1) || lose !== exp) begin
            n_err++; $display("FAIL ground: got state=%0d lose=%0b want %0d/%0b", state, lose, exp ? 2 : 1, exp);
        end
    endtask

    task automatic test_random();
        bit h [64];
        bit seen;
        int idx;
        for (int r = 0; r < 12; r++) begin
            do_reset();
            go_play();
            seen = 1'b0;
            for (int i = 0; i < 64; i++) begin
                idx = int'($urandom_range(0, 3));
                pipe_idx = 2'(idx);
                pipe_x   = 10'($urandom_range(0, 700));
                bird_y   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 479))
                                                       : 10'(gaps[idx] + int'($urandom_range(0, 100)));
                frame_tick = 1'($urandom_range(0, 1));
                start      = 1'($urandom_range(0, 1));
                h[i] = model_hit(int'(pipe_x), idx, int'(bird_y));
                #1;
                n_vec++; if (count_en !== frame_tick) begin n_err++; $display("FAIL rand count_en r=%0d i=%0d: got %0b want %0b", r, i, count_en, frame_tick); end
                step();
                if (i >= 2 && h[i-2]) seen = 1'b1;
                n_vec++; if (gap_top !== 10'(gaps[idx])) begin n_err++; $display("FAIL rand gap_top r=%0d i=%0d: got %0d want %0d", r, i, gap_top, gaps[idx]); end
                n_vec++; if (state !== (seen ? 2'd2 : 2'd1) || lose !== seen) begin
                    n_err++; $display("FAIL rand state r=%0d i=%0d: got state=%0d lose=%0b want %0d/%0b", r, i, state, lose, seen ? 2 : 1, seen);
                end
                if (seen) break;
            end
            set_safe();
        end
    endtask

    initial begin
        set_safe();
        reset = 1'b1;
        test_reset();
        test_start();
        test_collide();
        test_hit_timer();
        test_edges();
        test_tick_and_hit();
        test_reset_mid_hit();
        test_ground();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/obstacle_logic.md
OBSTACLE_LOGIC -- requirements
Module: obstacle_logic

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BIRD_X, 240: bird left edge, pixels.
- BIRD_W, 20: bird width.
- BIRD_H, 20: bird height.
- PIPE_W, 80: pipe width.
- GAP_H, 120: vertical gap height.
- SCREEN_H, 480: playfield height.
- DEATH_FRAMES, 30: frames held in HIT.
- GAP_TOP0..GAP_TOP3, 100/220/60/300: gap top Y for each pipe index.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- frame_tick, in, 1: one-cycle pulse per frame.
- start, in, 1: player start/flap request.
- pipe_x, in, 10: left edge of the pipe in scope.
- pipe_idx, in, 2: index of the pipe in scope.
- bird_y, in, 10: bird top Y.
- count_en, out, 1: pipe-shift enable to the pipe-position store.
- game_rst, out, 1: one-cycle restart pulse to the pipe-position store.
- lose, out, 1: collision flag.
- gap_top, out, 10: registered gap top of the pipe in scope.
- state, out, 2: FSM state, for debug.

Function
REQ-003 The FSM SHALL have four states: IDLE=0, PLAY=1, HIT=2, OVER=3.
REQ-004 IDLE SHALL go to PLAY on start=1, and SHALL assert game_rst for that cycle.
REQ-005 PLAY SHALL go to HIT in the cycle after hit_q=1; start SHALL be ignored in PLAY.
REQ-006 HIT SHALL load a frame counter with DEATH_FRAMES-1, decrement it on each frame_tick, and go to OVER on the frame_tick at count 0.
REQ-007 OVER SHALL go to PLAY on start=1 with a one-cycle game_rst pulse; start in HIT SHALL be ignored.
REQ-008 count_en SHALL equal (state==PLAY) & frame_tick, combinationally.
REQ-009 lose SHALL be registered: 1 in HIT and OVER, 0 in IDLE and PLAY.
REQ-010 Pipeline stage 1 SHALL register gap_top from GAP_TOPn[pipe_idx], and SHALL register pipe_x and bird_y.
REQ-011 Pipeline stage 2 SHALL register hit_q = x_ovl & y_bad, where:
- x_ovl = (px < BIRD_X+BIRD_W) & (px+PIPE_W > BIRD_X)
- y_bad = (by < gap_top) | (by+BIRD_H > gap_top+GAP_H)
REQ-012 All sums SHALL be computed at 11 bits with no truncation; pipe_x=640 (off-screen rollover value) SHALL yield x_ovl=0.
REQ-013 Latency from a colliding input to lose=1 SHALL be 3 cycles: stage 1, stage 2, then the state register.
REQ-014 Boundary conditions:
- Edge-touch (px+PIPE_W == BIRD_X, or by+BIRD_H == gap_top+GAP_H) SHALL NOT be a hit.
- A hit and a frame_tick in the same cycle SHALL produce count_en=1 for that cycle and HIT on the next cycle.
- hit_q SHALL be evaluated only in PLAY.

Reset
REQ-015 reset SHALL force, on the next edge and from any state including mid-HIT:
- state=IDLE, lose=0, game_rst=0, gap_top=0, hit_q=0, frame counter=0.
- count_en SHALL be 0 while in IDLE.

Configuration
REQ-016 With OBSTACLE_GROUND_COLLIDE_EN defined, stage 2 SHALL also set hit_q when by==0 or by+BIRD_H >= SCREEN_H.
REQ-017 Without OBSTACLE_GROUND_COLLIDE_EN, only pipe collisions SHALL set hit_q.

Structure
REQ-018 A shared package SHALL hold:
- the state encoding constants;
- SCREEN_H, PIPE_W, BIRD_X, BIRD_W, BIRD_H;
- the pipe-index width (2) and coordinate width (10), shared with the pipe-position store.
REQ-019 The gap lookup and the two-stage compare SHALL be one sub-module, obstacle_hit_detect; the FSM SHALL remain in the top.

Verification
REQ-020 Reset then start=1: game_rst pulses 1 cycle, state=PLAY, and count_en mirrors frame_tick.
REQ-021 pipe_idx=1, pipe_x=200, bird_y=150 (gap 220..340): lose=1 exactly 3 cycles later, and count_en=0 thereafter.
REQ-022 pipe_idx=1, pipe_x=200, bird_y=250: no hit. pipe_x=160 (edge touch, 160+80=240): no hit.
REQ-023 In HIT, 30 frame_ticks: OVER reached on the 30th. start=1 during HIT is ignored; start=1 in OVER gives game_rst pulse and state=PLAY.
REQ-024 reset asserted in HIT at tick 10: next cycle state=IDLE, lose=0.
REQ-025 bird_y=470 with no pipe overlap: hit with OBSTACLE_GROUND_COLLIDE_EN defined, no hit without it.
